uart_byte_receiver: RTL

UART_BYTE_RECEIVER -- requirements
Module: uart_byte_receiver

---
 rtl/uart_pkg.sv | 15 +
 rtl/rx_synchronizer.sv | 26 ++
 rtl/uart_byte_receiver.sv | 134 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte receiver: FSM state encoding and the
// default bit period for a 12 MHz clock at 115200 baud.
package uart_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 104;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_DATA       = 3'd2,
    ST_STOP       = 3'd3,
    ST_BREAK_WAIT = 3'd4
  } uart_state_e;

endpackage

// File: rtl/rx_synchronizer.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops reset
// high so the receiver sees an idle line straight out of reset.
module rx_synchronizer (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  // Double-register the line; no logic between the two stages.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver: samples each bit at its midpoint, strobes rx_data_ready
// on a good stop bit and frame_error on a low one (once per break).
module uart_byte_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_data_ready,
  output logic       frame_error,
  output logic       busy
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] BIT_HALF = TW'((CLKS_PER_BIT - 1) / 2);

  logic          rx_s;
  uart_state_e   state_q;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    rx_data_q;
  logic          ready_q;
  logic          ferr_q;
  logic          busy_q;
  logic          bit_end_s;
  logic          mid_bit_s;

  rx_synchronizer u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (uart_rx),
    .sync_o  (rx_s)
  );

  // Bit-timer increment and the two sample points it is compared against.
  always_comb begin
    timer_d   = timer_q + TW'(1);
    bit_end_s = (timer_q == BIT_LAST);
    mid_bit_s = (timer_q == BIT_HALF);
  end

  // Receive FSM with registered strobes; after START the timer is re-zeroed at
  // mid-bit, so every later full-period wrap lands on a bit centre.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= {TW{1'b0}};
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      rx_data_q <= 8'h00;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_q <= ST_START;
            timer_q <= {TW{1'b0}};
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (mid_bit_s) begin
            timer_q <= {TW{1'b0}};
            if (!rx_s) begin
              state_q <= ST_DATA;
              idx_q   <= 3'd0;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            timer_q <= timer_d;
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            timer_q        <= {TW{1'b0}};
            shift_q[idx_q] <= rx_s;
            if (idx_q == 3'd7) begin
              state_q <= ST_STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            timer_q <= timer_d;
          end
        end
        ST_STOP: begin
          if (bit_end_s) begin
            timer_q <= {TW{1'b0}};
            if (rx_s) begin
              rx_data_q <= shift_q;
              ready_q   <= 1'b1;
              state_q   <= ST_IDLE;
              busy_q    <= 1'b0;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= ST_BREAK_WAIT;
            end
          end else begin
            timer_q <= timer_d;
          end
        end
        ST_BREAK_WAIT: begin
          if (rx_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          timer_q <= {TW{1'b0}};
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_data_ready = ready_q;
  assign frame_error   = ferr_q;
  assign busy          = busy_q;

endmodule
